lcd_fb_arbiter: RTL

Framebuffer port arbiter and line-fetch sequencer for the LCD scanout path. It owns the single port of the frame SRAM and shares it between two requesters. The display line prefetcher has priority and copies one full line into the line buffer once per line request. The pixel writer (drawing engine or CPU) gets every idle cycle, plus one guaranteed slot every `WR_SLOT` cycles during a fetch. The block sits between the LCD timing generator and the frame SRAM, in the `CLK` domain.

---
 rtl/lcd_fb_pkg.sv | 15 +
 rtl/lcd_fb_fetch_ctr.sv | 72 +++++++
 rtl/lcd_fb_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/lcd_fb_pkg.sv
// Shared FSM encoding, panel geometry and pixel type for the LCD framebuffer arbiter.
// The latency and backpressure rules live in lcd_fb_arbiter.
package lcd_fb_pkg;
    localparam int DATA_W      = 16;
    localparam int LINE_PIXELS = 480;
    localparam int LINES       = 272;

    typedef logic [DATA_W-1:0] pix_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/lcd_fb_fetch_ctr.sv
// Line-fetch counters (base, column, writer slot) plus the 1-cycle read-return pipe.
// A read issued in cycle n shows up on pix_wvalid/pix_waddr in cycle n+1; the pipe never stalls.
module lcd_fb_fetch_ctr #(
    parameter int ADDR_W      = 17,
    parameter int LINE_PIXELS = lcd_fb_pkg::LINE_PIXELS,
    parameter int WR_SLOT     = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  lcd_fb_pkg::state_e state,
    input  logic               start,
    input  logic [8:0]         line_idx,
    input  logic               rd_issue,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               last_col,
    output logic               wr_slot,
    output logic               pix_wvalid,
    output logic [8:0]         pix_waddr
);
    import lcd_fb_pkg::*;

    localparam int SLOT_W = (WR_SLOT > 1) ? $clog2(WR_SLOT) : 1;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [8:0]        col_q, col_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              pix_wvalid_q;
    logic [8:0]        pix_waddr_q;

    assign wr_slot  = (WR_SLOT != 0) && (int'(slot_q) == WR_SLOT - 1);
    assign last_col = (int'(col_q) == LINE_PIXELS - 1);
    assign rd_addr  = base_q + ADDR_W'(col_q);

    always_comb begin
        base_d = base_q;
        col_d  = col_q;
        slot_d = slot_q;
        if (start) begin
            base_d = ADDR_W'(int'(line_idx) * LINE_PIXELS);
            col_d  = '0;
            slot_d = '0;
        end else if (state == ST_FETCH) begin
            if (rd_issue)
                col_d = col_q + 9'd1;
            // Slot free-runs during the fetch, taken or not.
            if (WR_SLOT < 2 || wr_slot)
                slot_d = '0;
            else
                slot_d = slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            base_q       <= '0;
            col_q        <= '0;
            slot_q       <= '0;
            pix_wvalid_q <= 1'b0;
            pix_waddr_q  <= '0;
        end else begin
            base_q       <= base_d;
            col_q        <= col_d;
            slot_q       <= slot_d;
            pix_wvalid_q <= rd_issue;
            if (rd_issue)
                pix_waddr_q <= col_q;
        end
    end

    assign pix_wvalid = pix_wvalid_q;
    assign pix_waddr  = pix_waddr_q;
endmodule

// File: rtl/lcd_fb_arbiter.sv
// Frame SRAM port arbiter: line prefetch has priority, the writer gets idle cycles and every WR_SLOT-th fetch cycle.
// Reads return 1 cycle after issue; writer backpressure is wr_ready only. LCD_FB_ARB_STATS_EN adds wr_stall_cnt.
module lcd_fb_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = lcd_fb_pkg::DATA_W,
    parameter int LINE_PIXELS = lcd_fb_pkg::LINE_PIXELS,
    parameter int LINES       = lcd_fb_pkg::LINES,
    parameter int WR_SLOT     = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              line_req,
    input  logic [8:0]        line_idx,
    output logic              line_busy,
    output logic              pix_wvalid,
    output logic [8:0]        pix_waddr,
    output logic [DATA_W-1:0] pix_wdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              underrun_clr,
    output logic              underrun
`ifdef LCD_FB_ARB_STATS_EN
    ,
    output logic [15:0]       wr_stall_cnt
`endif
);
    import lcd_fb_pkg::*;

    state_e            state_q, state_d;
    logic              underrun_q, underrun_d;
    logic              start, rd_issue, wr_xfer, wr_slot, last_col;
    logic [ADDR_W-1:0] rd_addr;

    assign start    = (state_q == ST_IDLE) && line_req && (int'(line_idx) < LINES);
    assign wr_ready = (state_q != ST_FETCH) || wr_slot;
    assign wr_xfer  = wr_valid && wr_ready;
    // An unclaimed writer slot falls through to a read so the fetch never idles.
    assign rd_issue = (state_q == ST_FETCH) && !wr_xfer;

    lcd_fb_fetch_ctr #(
        .ADDR_W      (ADDR_W),
        .LINE_PIXELS (LINE_PIXELS),
        .WR_SLOT     (WR_SLOT)
    ) u_ctr (
        .CLK        (CLK),
        .RST        (RST),
        .state      (state_q),
        .start      (start),
        .line_idx   (line_idx),
        .rd_issue   (rd_issue),
        .rd_addr    (rd_addr),
        .last_col   (last_col),
        .wr_slot    (wr_slot),
        .pix_wvalid (pix_wvalid),
        .pix_waddr  (pix_waddr)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: if (rd_issue && last_col) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        underrun_d = underrun_q;
        if (line_req && state_q != ST_IDLE)
            underrun_d = 1'b1;
        else if (underrun_clr)
            underrun_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            underrun_q <= underrun_d;
        end
    end

    assign line_busy = (state_q != ST_IDLE);
    assign underrun  = underrun_q;
    assign mem_en    = wr_xfer || rd_issue;
    assign mem_we    = wr_xfer;
    assign mem_addr  = wr_xfer ? wr_addr : rd_addr;
    assign mem_wdata = wr_data;
    // SRAM output is the return register; gating drops data from reads cut off by reset.
    assign pix_wdata = pix_wvalid ? mem_rdata : '0;

`ifdef LCD_FB_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge CLK) begin
        if (RST || start)
            stall_q <= '0;
        else if (wr_valid && !wr_ready && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign wr_stall_cnt = stall_q;
`endif
endmodule
